// File: rtl/vid_pkg.sv
// vid_pkg: axis state encodings, default 640x480 timing and colour-bar helper
package vid_pkg;

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNCP, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNCP, V_BACK} v_state_t;

    localparam int unsigned DEF_H_ACT  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_ACT  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    // bar order white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
        return {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    endfunction

endpackage

// File: rtl/vid_axis_fsm.sv
// vid_axis_fsm: four-phase axis counter (active, front porch, sync, back porch)
module vid_axis_fsm #(
    parameter int unsigned D0 = 640,
    parameter int unsigned D1 = 16,
    parameter int unsigned D2 = 96,
    parameter int unsigned D3 = 48
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] st_o,
    output logic [9:0] cnt_o,
    output logic       last_o
);
    logic [1:0] st_q, st_d;
    logic [9:0] cnt_q, cnt_d, dur;

    assign dur    = st_q == 2'd0 ? 10'(D0) : st_q == 2'd1 ? 10'(D1) : st_q == 2'd2 ? 10'(D2) : 10'(D3);
    assign last_o = cnt_q == dur - 10'd1;
    assign st_o   = st_q;
    assign cnt_o  = cnt_q;

    // clear wins over advance; the final count of a phase steps to the next phase
    always_comb begin
        st_d  = clr_i ? 2'd0 : (adv_i && last_o) ? st_q + 2'd1 : st_q;
        cnt_d = clr_i ? 10'd0 : !adv_i ? cnt_q : last_o ? 10'd0 : cnt_q + 10'd1;
    end

    // phase and count registers
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            st_q  <= 2'd0;
            cnt_q <= 10'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end

endmodule

// File: rtl/vid_timing_ctrl.sv
// vid_timing_ctrl: raster timing generator with line prefetch handshake; VID_TEST_PATTERN_EN selects colour bars
module vid_timing_ctrl
    import vid_pkg::*;
#(
    parameter int unsigned H_ACT    = DEF_H_ACT,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACT    = DEF_V_ACT,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        osc_clk,
    input  logic        reset_,
    input  logic        en,
    input  logic [23:0] pix_rgb,
    input  logic        line_ack,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic        line_req,
    output logic [9:0]  line_num,
    output logic        underrun,
    output logic        frame_start,
    output logic        vo_hsync,
    output logic        vo_vsync,
    output logic        vo_blank_,
    output logic [7:0]  vo_r,
    output logic [7:0]  vo_g,
    output logic [7:0]  vo_b
);
    logic        run_q, req_q, und_q;
    logic [9:0]  num_q;
    logic [1:0]  h_raw, v_raw;
    h_state_t    h_st;
    v_state_t    v_st;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_last, v_last, adv, line_end, req_set, deadline;
    logic        s1_bn_q, s1_hs_q, s1_vs_q, bn_q, hs_q, vs_q;
    logic [23:0] rgb_q, rgb_d;

    // counters only move once a cycle of en=1 has been seen, so the first shown pixel is (0,0)
    assign adv      = run_q & en;
    assign line_end = adv && h_st == H_BACK && h_last;

    vid_axis_fsm #(.D0(H_ACT), .D1(H_FP), .D2(H_SYNC), .D3(H_BP)) u_h (
        .clk_i(osc_clk), .rst_ni(reset_), .clr_i(!en), .adv_i(adv),
        .st_o(h_raw), .cnt_o(h_cnt), .last_o(h_last)
    );

    vid_axis_fsm #(.D0(V_ACT), .D1(V_FP), .D2(V_SYNC), .D3(V_BP)) u_v (
        .clk_i(osc_clk), .rst_ni(reset_), .clr_i(!en), .adv_i(line_end),
        .st_o(v_raw), .cnt_o(v_cnt), .last_o(v_last)
    );

    assign h_st        = h_state_t'(h_raw);
    assign v_st        = v_state_t'(v_raw);
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign pix_valid   = run_q && h_st == H_ACTIVE && v_st == V_ACTIVE;
    assign frame_start = pix_valid && h_cnt == 10'd0 && v_cnt == 10'd0;

    // request lands on the first H_SYNCP clock of any line that is followed by an active line
    assign req_set  = adv && h_st == H_FRONT && h_last &&
                      ((v_st == V_BACK && v_last) || (v_st == V_ACTIVE && v_cnt != 10'(V_ACT - 1)));
    assign deadline = run_q && h_st == H_ACTIVE && h_cnt == 10'd0;

    // prefetch handshake and sticky underrun; an ack at the deadline still counts as on time
    always_ff @(posedge osc_clk or negedge reset_)
        if (!reset_) begin
            run_q <= 1'b0;
            req_q <= 1'b0;
            num_q <= 10'd0;
            und_q <= 1'b0;
        end else if (!en) begin
            run_q <= 1'b0;
            req_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (req_set) begin
                req_q <= 1'b1;
                num_q <= v_st == V_ACTIVE ? v_cnt + 10'd1 : 10'd0;
            end else if (req_q && (line_ack || deadline)) begin
                req_q <= 1'b0;
            end
            if (req_q && deadline && !line_ack) und_q <= 1'b1;
        end

    assign line_req = req_q;
    assign line_num = num_q;
    assign underrun = und_q;

`ifdef VID_TEST_PATTERN_EN
    logic [9:0] s1_x_q;
    logic       unused_rgb;
    assign unused_rgb = ^pix_rgb;
    assign rgb_d      = bar_rgb(3'((32'(s1_x_q) * 32'd8) / H_ACT));
    // column of the stage-1 pixel selects its colour bar
    always_ff @(posedge osc_clk or negedge reset_)
        if (!reset_) s1_x_q <= 10'd0;
        else s1_x_q <= en ? h_cnt : 10'd0;
`else
    assign rgb_d = pix_rgb;
`endif

    // two-stage output pipeline; pixel data arrives alongside stage 1, en=0 blanks both stages
    always_ff @(posedge osc_clk or negedge reset_)
        if (!reset_ || !en) begin
            s1_bn_q <= 1'b0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
            bn_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            rgb_q   <= 24'd0;
        end else begin
            s1_bn_q <= pix_valid;
            s1_hs_q <= h_st == H_SYNCP;
            s1_vs_q <= v_st == V_SYNCP;
            bn_q    <= s1_bn_q;
            hs_q    <= s1_hs_q;
            vs_q    <= s1_vs_q;
            rgb_q   <= s1_bn_q ? rgb_d : 24'd0;
        end

    assign vo_hsync  = hs_q ? SYNC_POL : ~SYNC_POL;
    assign vo_vsync  = vs_q ? SYNC_POL : ~SYNC_POL;
    assign vo_blank_ = bn_q;
    assign {vo_r, vo_g, vo_b} = rgb_q;

endmodule

// File: tb/tb_vid_timing_ctrl.sv
// tb_vid_timing_ctrl: randomized scoreboard bench for vid_timing_ctrl on a 15x7 raster
module tb_vid_timing_ctrl;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit SYNC_POL = 1'b0;

    logic        osc_clk, reset_, en, line_ack;
    logic [23:0] pix_rgb;
    logic [9:0]  pix_x, pix_y, line_num;
    logic        pix_valid, line_req, underrun, frame_start, vo_hsync, vo_vsync, vo_blank_;
    logic [7:0]  vo_r, vo_g, vo_b;

    vid_timing_ctrl #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(SYNC_POL)
    ) dut (
        .osc_clk(osc_clk), .reset_(reset_), .en(en), .pix_rgb(pix_rgb), .line_ack(line_ack),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .line_req(line_req),
        .line_num(line_num), .underrun(underrun), .frame_start(frame_start),
        .vo_hsync(vo_hsync), .vo_vsync(vo_vsync), .vo_blank_(vo_blank_),
        .vo_r(vo_r), .vo_g(vo_g), .vo_b(vo_b)
    );

    typedef struct packed {logic pv; logic [9:0] x; logic hs, vs;} cmb_t;
    typedef struct packed {logic pv, fs, req, und, hs, vs, bn; logic [9:0] x, y, num;} exp_t;

    exp_t        q_exp[$];
    logic [23:0] q_rgb[$];
    exp_t        me;
    logic [23:0] mr;
    int          checks = 0, errors = 0;

    bit   run = 0, req = 0, und = 0;
    int   t = 0, num = 0;
    cmb_t d1 = '0, d2 = '0;
    int   ack_dly = 3, age = 0;
    bit   stray = 1;

`ifdef VID_TEST_PATTERN_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, r, $time);
        end
    endtask

    function automatic cmb_t comb(input bit r, input int tt);
        cmb_t c;
        int hp, ln;
        hp = tt % HT;
        ln = tt / HT;
        c.pv = r && hp < HA && ln < VA;
        c.x  = 10'(hp);
        c.hs = hp >= HA + HF && hp < HA + HF + HS;
        c.vs = ln >= VA + VF && ln < VA + VF + VS;
        return c;
    endfunction

    // reference: advance one clock from the raster position and sampled inputs
    task automatic upd();
        cmb_t c;
        int hp, ln;
        c  = comb(run, t);
        hp = t % HT;
        ln = t / HT;
        if (!en) begin
            req = 0;
            und = 0;
        end else if (run) begin
            if (req && hp == 0) begin
                req = 0;
                if (!line_ack) und = 1;
            end else if (req && line_ack) begin
                req = 0;
            end
            if (hp == HA + HF - 1 && (ln == VT - 1 || ln < VA - 1)) begin
                req = 1;
                num = ln == VT - 1 ? 0 : ln + 1;
            end
        end
        d2 = en ? d1 : '0;
        d1 = en ? c : '0;
        if (!en) q_rgb.delete();
        if (!en) begin
            run = 0;
            t   = 0;
        end else if (run) t = (t + 1) % FT;
        else run = 1;
    endtask

    task automatic push();
        cmb_t c;
        exp_t e;
        c     = comb(run, t);
        e.pv  = c.pv;
        e.x   = c.x;
        e.y   = 10'(t / HT);
        e.fs  = c.pv && t == 0;
        e.req = req;
        e.num = 10'(num);
        e.und = und;
        e.hs  = d2.hs;
        e.vs  = d2.vs;
        e.bn  = d2.pv;
        q_exp.push_back(e);
`ifdef VID_TEST_PATTERN_EN
        if (d1.pv) q_rgb.push_back(bars[(int'(d1.x) * 8) / HA]);
`else
        if (d1.pv) q_rgb.push_back(pix_rgb);
`endif
    endtask

    task automatic step();
        @(posedge osc_clk);
        upd();
        #1;
        age      = line_req ? age + 1 : 0;
        line_ack = (ack_dly > 0 && age == ack_dly + 1) || (stray && !line_req && $urandom_range(3) == 0);
        pix_rgb  = 24'($urandom);
        push();
    endtask

    task automatic chk_reset();
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_x", 32'(pix_x), 0);
        chk("rst_pix_y", 32'(pix_y), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_line_req", 32'(line_req), 0);
        chk("rst_line_num", 32'(line_num), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_vo_blank_", 32'(vo_blank_), 0);
        chk("rst_vo_hsync", 32'(vo_hsync), 32'(!SYNC_POL));
        chk("rst_vo_vsync", 32'(vo_vsync), 32'(!SYNC_POL));
        chk("rst_vo_rgb", 32'({vo_r, vo_g, vo_b}), 0);
    endtask

    task automatic model_reset();
        q_exp.delete();
        q_rgb.delete();
        run = 0; t = 0; req = 0; und = 0; num = 0;
        d1 = '0; d2 = '0; age = 0;
    endtask

    // monitor: pop one expectation per cycle, pixel data when the DUT shows it
    always @(negedge osc_clk)
        if (q_exp.size() > 0) begin
            me = q_exp.pop_front();
            chk("pix_valid", 32'(pix_valid), 32'(me.pv));
            if (me.pv) begin
                chk("pix_x", 32'(pix_x), 32'(me.x));
                chk("pix_y", 32'(pix_y), 32'(me.y));
            end
            chk("frame_start", 32'(frame_start), 32'(me.fs));
            chk("line_req", 32'(line_req), 32'(me.req));
            if (me.req) chk("line_num", 32'(line_num), 32'(me.num));
            chk("underrun", 32'(underrun), 32'(me.und));
            chk("vo_hsync", 32'(vo_hsync), 32'(me.hs ? SYNC_POL : !SYNC_POL));
            chk("vo_vsync", 32'(vo_vsync), 32'(me.vs ? SYNC_POL : !SYNC_POL));
            chk("vo_blank_", 32'(vo_blank_), 32'(me.bn));
            if (vo_blank_) begin
                if (q_rgb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vo_rgb: got %0h expected no pixel at %0t", {vo_r, vo_g, vo_b}, $time);
                end else begin
                    mr = q_rgb.pop_front();
                    chk("vo_rgb", 32'({vo_r, vo_g, vo_b}), 32'(mr));
                end
            end else begin
                chk("vo_rgb_blank", 32'({vo_r, vo_g, vo_b}), 0);
            end
        end

    initial begin
        reset_   = 1'b0;
        en       = 1'b1;
        line_ack = 1'b0;
        pix_rgb  = 24'd0;
        #3;
        chk_reset();
        #9;
        reset_ = 1'b1;
        repeat (220) step();
        for (int i = 0; i < 300 && !(run && t == 2 * HT + 5); i++) step();
        checks++;
        if (!(run && t == 2 * HT + 5)) begin
            errors++;
            $display("FAIL wait_pixel_5_2: got t=%0d expected t=%0d", t, 2 * HT + 5);
        end
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        repeat (120) step();
        ack_dly = 5;
        stray   = 0;
        repeat (110) step();
        en = 1'b0;
        step();
        en      = 1'b1;
        ack_dly = 0;
        repeat (130) step();
        #2;
        reset_ = 1'b0;
        #1;
        chk_reset();
        model_reset();
        line_ack = 1'b0;
        @(posedge osc_clk);
        @(posedge osc_clk);
        #7;
        reset_  = 1'b1;
        ack_dly = 3;
        stray   = 1;
        repeat (120) step();
        @(negedge osc_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
